// File: rtl/gpio_serial_config_tx.sv
// Serial programmer for the mprj_io pad control daisy chain: captures a
// configuration image, shifts it out MSB-first, then strobes serial_load.
module gpio_serial_config_tx #(
  parameter int unsigned NUM_PADS     = 38,
  parameter int unsigned BITS_PER_PAD = 13,
  parameter int unsigned CLK_DIV      = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_PADS*BITS_PER_PAD-1:0] cfg_data,
  output logic                             busy,
  output logic                             done,
  output logic                             serial_clock,
  output logic                             serial_data,
  output logic                             serial_load
);

  localparam int unsigned N  = NUM_PADS * BITS_PER_PAD;
  localparam int unsigned BW = $clog2(N + 1);
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
  localparam logic [BW-1:0] BIT_MAX  = BW'(N);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    GAP,
    LOAD,
    DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [N-1:0]   r_shreg;
  logic [7:0]     r_div;
  logic           r_phase;
  logic [BW-1:0]  r_bit;
  logic           r_busy;
  logic           r_done;
  logic           r_sclk;
  logic           r_sdata;
  logic           r_sload;
  logic           w_div_last;
  logic           w_bit_end;
  logic           w_accept;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_div_last   = (r_div == DIV_LAST);
    w_bit_end    = w_div_last && r_phase;
    case (r_state)
      IDLE: begin
        // The serial outputs lag the state by one cycle, so the visible done
        // cycle is spent in IDLE; r_done blocks a start landing in it.
        if (start && !r_done) begin
          w_accept     = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (w_bit_end && (r_bit == BIT_LAST)) begin
          w_state_next = GAP;
        end
      end
      GAP: begin
        if (w_div_last) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        if (w_div_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_div   <= '0;
      r_phase <= 1'b0;
      r_bit   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_sload <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sclk  <= (r_state == SHIFT) && r_phase;
      r_sdata <= (r_state == SHIFT) && r_shreg[N-1];
      r_sload <= (r_state == LOAD);
      r_done  <= (r_state == DONE);

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= cfg_data;
            r_div   <= '0;
            r_phase <= 1'b0;
            r_bit   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_div <= w_div_last ? '0 : r_div + 8'd1;
          if (w_div_last) begin
            r_phase <= ~r_phase;
            if (r_phase) begin
              r_shreg <= {r_shreg[N-2:0], 1'b0};
              r_bit   <= r_bit + BW'(1);
            end
          end
        end
        GAP, LOAD: begin
          r_div <= w_div_last ? '0 : r_div + 8'd1;
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign serial_clock = r_sclk;
  assign serial_data  = r_sdata;
  assign serial_load  = r_sload;

  a_clk_load_exclusive : assert property (@(posedge clock) disable iff (reset)
    !(serial_clock && serial_load));

  a_bit_bounded : assert property (@(posedge clock) disable iff (reset)
    r_bit <= BIT_MAX);

endmodule

// File: tb/tb_gpio_serial_config_tx.sv
// Bench for gpio_serial_config_tx: three instances (8-bit chain at CLK_DIV 1
// and 3, full 38x13 chain) observed through a daisy-chain model and scoreboard.
module tb_gpio_serial_config_tx;

  localparam int NW = 494;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]    rs;
  logic [2:0]    st;
  logic [7:0]    cfg0;
  logic [7:0]    cfg1;
  logic [NW-1:0] cfg2;

  logic bz0, dn0, sc0, sd0, sl0;
  logic bz1, dn1, sc1, sd1, sl1;
  logic bz2, dn2, sc2, sd2, sl2;
  logic [2:0] bz, dn, sc, sd, sl;
  assign bz = {bz2, bz1, bz0};
  assign dn = {dn2, dn1, dn0};
  assign sc = {sc2, sc1, sc0};
  assign sd = {sd2, sd1, sd0};
  assign sl = {sl2, sl1, sl0};

  gpio_serial_config_tx #(.NUM_PADS(2), .BITS_PER_PAD(4), .CLK_DIV(1)) u_div1 (
    .clock(clk), .reset(rs[0]), .start(st[0]), .cfg_data(cfg0),
    .busy(bz0), .done(dn0), .serial_clock(sc0), .serial_data(sd0), .serial_load(sl0));

  gpio_serial_config_tx #(.NUM_PADS(2), .BITS_PER_PAD(4), .CLK_DIV(3)) u_div3 (
    .clock(clk), .reset(rs[1]), .start(st[1]), .cfg_data(cfg1),
    .busy(bz1), .done(dn1), .serial_clock(sc1), .serial_data(sd1), .serial_load(sl1));

  gpio_serial_config_tx #(.NUM_PADS(38), .BITS_PER_PAD(13), .CLK_DIV(2)) u_full (
    .clock(clk), .reset(rs[2]), .start(st[2]), .cfg_data(cfg2),
    .busy(bz2), .done(dn2), .serial_clock(sc2), .serial_data(sd2), .serial_load(sl2));

  function automatic int npads(input int i);
    return (i == 2) ? 38 : 2;
  endfunction
  function automatic int bpp(input int i);
    return (i == 2) ? 13 : 4;
  endfunction
  function automatic int cdiv(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 3 : 2);
  endfunction

  typedef struct {
    int            inst;
    logic [NW-1:0] img;
    int            sedge;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [7:0] cfg;
    logic [3:0] pad1;
    logic [3:0] pad0;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap = 0;

  logic [NW-1:0] chain [3];
  logic [NW-1:0] latched [3];
  bit   psc [3];
  int   nrise [3];
  int   nload [3];
  int   ndone [3];
  int   hrun [3];
  int   hmin [3];
  int   hmax [3];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_done(input int i);
    sb_t e;
    logic [NW-1:0] a;
    logic [NW-1:0] x;
    int b;
    int c;
    int unsigned mask;
    if (sbq.size() == 0 || sbq[0].inst != i) begin
      chk($sformatf("unexpected_done_inst%0d", i), 64'd1, 64'd0);
      return;
    end
    e = sbq.pop_front();
    b = bpp(i);
    c = cdiv(i);
    mask = (32'd1 << b) - 1;
    chk($sformatf("latency_inst%0d", i), 64'(cyc - e.sedge),
        64'(npads(i) * b * 2 * c + 2 * c + 1));
    chk($sformatf("sclk_rises_inst%0d", i), 64'(nrise[i]), 64'(npads(i) * b));
    chk($sformatf("load_cycles_inst%0d", i), 64'(nload[i]), 64'(c));
    chk($sformatf("sclk_high_min_inst%0d", i), 64'(hmin[i]), 64'(c));
    chk($sformatf("sclk_high_max_inst%0d", i), 64'(hmax[i]), 64'(c));
    chk($sformatf("busy_at_done_inst%0d", i), 64'(bz[i]), 64'd0);
    for (int p = 0; p < npads(i); p++) begin
      a = latched[i] >> (p * b);
      x = e.img >> (p * b);
      chk($sformatf("pad%0d_inst%0d", p, i), 64'(a[31:0] & mask), 64'(x[31:0] & mask));
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sc[i] && !psc[i]) begin
        chain[i] = {chain[i][NW-2:0], sd[i]};
        nrise[i]++;
        hrun[i] = 1;
      end else if (sc[i]) begin
        hrun[i]++;
      end
      if (!sc[i] && psc[i]) begin
        if (hrun[i] < hmin[i]) hmin[i] = hrun[i];
        if (hrun[i] > hmax[i]) hmax[i] = hrun[i];
      end
      if (sl[i]) begin
        nload[i]++;
        latched[i] = chain[i];
      end
      if (sl[i] && sc[i]) overlap++;
      if (dn[i]) begin
        ndone[i]++;
        check_done(i);
      end
      psc[i] = sc[i];
    end
  end

  // Called at posedge+#1; start is sampled on the following edge.
  task automatic do_start(input int i, input logic [NW-1:0] cfg, input logic [NW-1:0] expimg);
    sb_t e;
    case (i)
      0: cfg0 = cfg[7:0];
      1: cfg1 = cfg[7:0];
      default: cfg2 = cfg;
    endcase
    nrise[i] = 0;
    nload[i] = 0;
    hmin[i]  = 1000;
    hmax[i]  = 0;
    e.inst  = i;
    e.img   = expimg;
    e.sedge = cyc + 1;
    sbq.push_back(e);
    st[i] = 1'b1;
    @(posedge clk);
    #1 st[i] = 1'b0;
  endtask

  // Returns at negedge+#1 of the cycle in which done is visible.
  task automatic wait_done(input int i, input int budget);
    int d0;
    int drops;
    bit seen;
    d0 = ndone[i];
    drops = 0;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (ndone[i] != d0) begin
        seen = 1;
        break;
      end
      if (!bz[i]) drops++;
    end
    chk($sformatf("done_seen_inst%0d", i), 64'(seen), 64'd1);
    chk($sformatf("busy_held_inst%0d", i), 64'(drops), 64'd0);
    if (!seen) sbq.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];
  logic [NW-1:0] img;
  int d0;

  initial begin
    vecs[0] = '{cfg: 8'hA5, pad1: 4'hA, pad0: 4'h5};
    vecs[1] = '{cfg: 8'h3C, pad1: 4'h3, pad0: 4'hC};
    vecs[2] = '{cfg: 8'h00, pad1: 4'h0, pad0: 4'h0};
    vecs[3] = '{cfg: 8'hFF, pad1: 4'hF, pad0: 4'hF};
    vecs[4] = '{cfg: 8'h81, pad1: 4'h8, pad0: 4'h1};
    vecs[5] = '{cfg: 8'h5A, pad1: 4'h5, pad0: 4'hA};
    for (int i = 0; i < 3; i++) begin
      chain[i] = '0;
      latched[i] = '0;
      hmin[i] = 1000;
    end
    rs = 3'b111;
    st = 3'b000;
    cfg0 = '0;
    cfg1 = '0;
    cfg2 = '0;
    step(3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_outputs_inst%0d", i), 64'({bz[i], dn[i], sc[i], sd[i], sl[i]}), 64'd0);
    rs = 3'b000;
    step(2);

    for (int v = 0; v < 6; v++) begin
      do_start(0, NW'(vecs[v].cfg), NW'({vecs[v].pad1, vecs[v].pad0}));
      wait_done(0, 100);
      step(2);
    end

    do_start(1, NW'(8'hA5), NW'({4'hA, 4'h5}));
    wait_done(1, 200);
    step(2);

    // Second start with a new image while busy must be ignored.
    d0 = ndone[0];
    do_start(0, NW'(8'hA5), NW'({4'hA, 4'h5}));
    step(3);
    cfg0 = 8'hFF;
    st[0] = 1'b1;
    step(1);
    st[0] = 1'b0;
    wait_done(0, 100);
    step(30);
    chk("single_done_on_restart", 64'(ndone[0] - d0), 64'd1);

    // Reset in the middle of shifting.
    do_start(0, NW'(8'hA5), NW'({4'hA, 4'h5}));
    step(6);
    rs[0] = 1'b1;
    step(1);
    rs[0] = 1'b0;
    sbq.delete();
    chk("mid_reset_outputs", 64'({bz[0], dn[0], sc[0], sd[0], sl[0]}), 64'd0);
    d0 = ndone[0];
    step(30);
    chk("mid_reset_no_load", 64'(nload[0]), 64'd0);
    chk("mid_reset_no_done", 64'(ndone[0] - d0), 64'd0);
    do_start(0, NW'(8'h3C), NW'({4'h3, 4'hC}));
    wait_done(0, 100);
    step(2);

    // Back-to-back: start in the done cycle ignored, start right after accepted.
    do_start(0, NW'(8'hA5), NW'({4'hA, 4'h5}));
    wait_done(0, 100);
    st[0] = 1'b1;
    step(1);
    st[0] = 1'b0;
    chk("start_in_done_ignored", 64'(bz[0]), 64'd0);
    do_start(0, NW'(8'h3C), NW'({4'h3, 4'hC}));
    chk("start_after_done_busy", 64'(bz[0]), 64'd1);
    wait_done(0, 100);
    step(2);

    for (int k = 0; k < NW; k++) img[k] = 1'($urandom_range(1, 0));
    do_start(2, img, img);
    wait_done(2, 3000);
    step(2);

    chk("clock_load_overlap", 64'(overlap), 64'd0);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
